// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Pure declarations; no logic, no latency.
// No flow control of its own.
package if_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } if_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush > stall > load > bubble priority.
// Latency: one cycle from load to visible output.
// Backpressure: stall holds every field; flush wins over stall.
module if_id_reg
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic            id_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc    <= '0;
            id_instr <= NOP;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_instr <= NOP;
            id_valid <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                id_pc    <= load_pc;
                id_instr <= load_instr;
                id_valid <= 1'b1;
            end else begin
                // Bubble keeps the PC so later stages still see a sensible address.
                id_instr <= NOP;
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, one outstanding imem request, feeds IF/ID.
// Latency: grant at n, rvalid at n+1, IF/ID valid at n+2 (1 instr / 2 cycles).
// Backpressure: stall parks a returned instruction in a 1-entry buffer and stops requests.
module if_stage
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP      = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_instr,
    output logic            IF_ID_valid,
    output logic [4:0]      IF_ID_rs1,
    output logic [4:0]      IF_ID_rs2
);

    if_state_t       state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_fetch;
    logic [XLEN-1:0] buf_pc;
    logic [XLEN-1:0] buf_instr;
    logic            drop;

    logic            load;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] load_instr;

    // Request is masked while reset is held so nothing escapes before release.
    assign imem_req  = rst_n && (state == REQ);
    assign imem_addr = pc;

    always_comb begin
        load       = 1'b0;
        load_pc    = pc_fetch;
        load_instr = imem_rdata;
        if (!flush && !stall) begin
            if (state == WAIT && imem_rvalid && !drop) begin
                load = 1'b1;
            end else if (state == HOLD) begin
                load       = 1'b1;
                load_pc    = buf_pc;
                load_instr = buf_instr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= REQ;
            pc        <= RESET_PC;
            pc_fetch  <= RESET_PC;
            drop      <= 1'b0;
            buf_pc    <= RESET_PC;
            buf_instr <= NOP;
        end else begin
            case (state)
                REQ: begin
                    if (flush) begin
                        pc <= redirect_pc;
                        if (imem_gnt) begin
                            drop  <= 1'b1;
                            state <= WAIT;
                        end
                    end else if (imem_gnt) begin
                        pc_fetch <= pc;
                        pc       <= pc + 32'd4;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        pc <= redirect_pc;
                        if (imem_rvalid) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else if (!stall) begin
                            state <= REQ;
                        end else begin
                            buf_pc    <= pc_fetch;
                            buf_instr <= imem_rdata;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (flush) begin
                        pc    <= redirect_pc;
                        state <= REQ;
                    end else if (!stall) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    if_id_reg #(.NOP(NOP)) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .stall      (stall),
        .load       (load),
        .load_pc    (load_pc),
        .load_instr (load_instr),
        .id_pc      (IF_ID_pc),
        .id_instr   (IF_ID_instr),
        .id_valid   (IF_ID_valid)
    );

    assign IF_ID_rs1 = IF_ID_instr[19:15];
    assign IF_ID_rs2 = IF_ID_instr[24:20];

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage core: owns the PC, issues one-outstanding-request fetches to instruction memory, and drives the IF/ID pipeline register. It consumes the load-use `stall` from the hazard unit and the EX-stage branch/jump `flush`/redirect. It supplies the decoded `IF_ID_rs1`/`IF_ID_rs2` fields back to the hazard unit.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  load-use stall from hazard unit; hold IF/ID
- `flush`  in  1  taken branch/jump resolved in EX
- `redirect_pc`  in  32  target PC, valid when `flush`=1
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 and not granted
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid, ≥1 cycle after grant
- `imem_rdata`  in  32  fetched instruction
- `IF_ID_pc`  out  32  PC of instruction in IF/ID
- `IF_ID_instr`  out  32  instruction in IF/ID
- `IF_ID_valid`  out  1  IF/ID holds a real instruction
- `IF_ID_rs1`, `IF_ID_rs2`  out  5  `IF_ID_instr[19:15]`, `[24:20]`, combinational

## Operation
- Registers: `pc` (next fetch), `pc_fetch` (outstanding address), `drop` flag, 1-entry buffer (`buf_pc`, `buf_instr`), FSM state, IF/ID register.
- FSM states: REQ, WAIT, HOLD.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_gnt`: `pc_fetch`<=`pc`, `pc`<=`pc`+4 (mod 2^32, wraps 0xFFFF_FFFC→0), go to WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`:
  - If `drop`=1, discard the response, clear `drop`, go to REQ.
  - Else if `stall`=0, load IF/ID {`pc_fetch`, `imem_rdata`, 1} and go to REQ.
  - Else, store the response in the buffer and go to HOLD.
- HOLD: `imem_req`=0. When `stall`=0, load IF/ID from the buffer and go to REQ.
- Flush overrides everything, in any state:
  - `pc`<=`redirect_pc`.
  - IF/ID<={`IF_ID_pc`, NOP, 0}.
  - REQ without gnt: stay in REQ. The address changes next cycle; this is the only permitted change of an ungranted request.
  - REQ with gnt, or WAIT: `drop`<=1 and go to/stay in WAIT.
  - WAIT with `imem_rvalid` in the same cycle: the response is discarded, `drop` stays 0, go to REQ.
  - HOLD: discard the buffer, go to REQ.
- IF/ID update priority: flush > stall (hold all fields) > new instruction > bubble. A bubble is `IF_ID_valid`<=0, `IF_ID_instr`<=NOP, `IF_ID_pc` held.
- A stall and a flush in the same cycle resolve as a flush.

## Timing
- Reset values (async, while `rst_n`=0):
  - state=REQ, `pc`=RESET_PC, `drop`=0.
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `IF_ID_pc`=0, `IF_ID_instr`=NOP, `IF_ID_valid`=0, rs1=rs2=0.
- `imem_req` is gated low during reset. It rises in the first cycle after `rst_n` deasserts, with `imem_addr`=RESET_PC.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight response after reset release arrives with state=REQ and is ignored; `imem_rvalid` is only sampled in WAIT.
- Latency with gnt in the same cycle and a 1-cycle response:
  - REQ(gnt) at cycle n, rvalid at n+1, IF/ID valid at n+2.
  - Throughput is 1 instruction per 2 cycles.
- Flush at cycle n: the IF/ID bubble is visible at n+1, and `imem_addr`=`redirect_pc` no later than n+1 (REQ state) or after the dropped response returns (WAIT).

## Structure
- Package `if_pkg`:
  - `if_state_t` enum {REQ, WAIT, HOLD}
  - `NOP_INSTR`
  - `RESET_PC_DEFAULT`
  - `XLEN`=32
- Sub-module `if_id_reg`: IF/ID register with a flush > stall > load > bubble priority.
- `if_stage` contains the FSM, PC, drop flag and buffer.

## Test plan
- Reset release, memory always granting with 1-cycle rvalid, rdata=addr → IF/ID pc = 0x0, 0x4, 0x8 on alternate cycles; `imem_addr`=0x0 in the first cycle.
- `stall`=1 for 3 cycles while in WAIT with rvalid → buffer captures 0x4; IF/ID holds 0x0 during the stall and shows 0x4 in the cycle after `stall` falls; no request is issued during HOLD.
- `flush`=1 with `redirect_pc`=0x100 in WAIT, rvalid 2 cycles later → that response is discarded, `IF_ID_valid`=0, and the next `imem_addr`=0x100.
- `flush` and `stall` in the same cycle → IF/ID becomes a bubble (NOP, valid=0), and `pc` becomes the redirect target.
- `imem_gnt` withheld for 4 cycles → `imem_req` and `imem_addr` are held stable; with `pc`=0xFFFF_FFFC, the next address wraps to 0x0.
- `rst_n` pulsed low while in WAIT → outputs return to reset values, and a late `imem_rvalid` does not load IF/ID.
